p08_seq_divider: RTL

Parametrised sequential restoring divider for the muldiv datapath. It replaces the combinational array of full-adder/mux divide cells with one shared subtract/restore stage that is iterated once per clock. It computes quotient and remainder of WIDTH-bit operands in unsigned or two's-complement mode, and flags divide-by-zero. A start/busy/done handshake connects it to the surrounding controller.

---
 rtl/p08_seq_divider.sv | 132 +++++++++++++
 1 files changed

// File: rtl/p08_seq_divider.sv
// Sequential restoring divider: one shared subtract/restore stage iterated once per clock,
// unsigned or two's-complement, with divide-by-zero flag and start/busy/done handshake.
module p08_seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] orig_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] prem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] rem_d;

    always_comb begin
        dvd_neg = sgn_i & dividend_i[WIDTH-1];
        dvs_neg = sgn_i & divisor_i[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend_i : dividend_i;
        dvs_mag = dvs_neg ? -divisor_i : divisor_i;
    end

    // Partial remainder stays below the divisor, so a WIDTH+1 bit trial never overflows and its
    // MSB is the borrow.
    always_comb begin
        shifted = {prem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        qbit    = ~trial[WIDTH];
        prem_d  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], qbit};
        quot_d  = zero_q ? {WIDTH{1'b1}} : (qneg_q ? -dvd_d : dvd_d);
        rem_d   = zero_q ? orig_q : (rneg_q ? -prem_d : prem_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            orig_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        prem_q  <= '0;
                        dvd_q   <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        orig_q  <= dividend_i;
                        qneg_q  <= dvd_neg ^ dvs_neg;
                        rneg_q  <= dvd_neg;
                        zero_q  <= (divisor_i == '0);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    prem_q <= prem_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= quot_d;
                        rem_q   <= rem_d;
                        dz_q    <= zero_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dz_q;

endmodule
